// File: rtl/ex_div_unit_pkg.sv
// Shared types and constants for the EX-stage RV32M divider.
package ex_div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_div_unit_if.sv
// EX <-> divider handshake bundle; master is the EX stage, slave is the divider.
interface ex_div_unit_if
  import ex_div_unit_pkg::*;
();
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      reg_waddr_i;
  logic            flush_i;
  logic [XLEN-1:0] result_o;
  logic [4:0]      reg_waddr_o;
  logic            ready_o;
  logic            busy_o;
  logic            stall_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    input  result_o, reg_waddr_o, ready_o, busy_o, stall_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    output result_o, reg_waddr_o, ready_o, busy_o, stall_o
  );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional early-out for zero or oversized divisors: define EX_DIV_FAST_EN.
//
// state    | meaning
// DIV_IDLE | waiting for start_i; latches |operands| and sign flags on accept
// DIV_CALC | XLEN shift/trial-subtract iterations
// DIV_DONE | result valid, ready_o pulses for one cycle
module ex_div_unit
  import ex_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  ex_div_unit_if.slave div_if
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return {XLEN{1'b0}} - v;
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? negate(v) : v;
  endfunction

  div_state_e       state_q, state_d;
  logic [XLEN-1:0]  rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       waddr_q, waddr_d;
  logic             rem_sel_q, rem_sel_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;

  logic            op_signed, accept, dvs_zero;
  logic [XLEN-1:0] abs_a, abs_b, quot_fix, rem_fix;
  logic [XLEN:0]   shifted, diff;

  assign op_signed = ~div_if.op_i[0];
  assign abs_a     = abs_val(div_if.dividend_i, op_signed);
  assign abs_b     = abs_val(div_if.divisor_i, op_signed);
  assign dvs_zero  = (div_if.divisor_i == {XLEN{1'b0}});
  // Only funct3 1xx is an M-extension divide; anything else is not accepted.
  assign accept    = (state_q == DIV_IDLE) & div_if.start_i & ~div_if.flush_i & div_if.op_i[2];

  // Partial remainder can reach 2*divisor-1, hence one extra bit.
  assign shifted = {rem_q, quot_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DIV_IDLE;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      waddr_q    <= '0;
      rem_sel_q  <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      waddr_q    <= waddr_d;
      rem_sel_q  <= rem_sel_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    waddr_d    = waddr_q;
    rem_sel_d  = rem_sel_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          rem_sel_d  = div_if.op_i[1];
          waddr_d    = div_if.reg_waddr_i;
          quot_d     = abs_a;
          rem_d      = '0;
          dvs_d      = abs_b;
          cnt_d      = '0;
          neg_quot_d = op_signed & (div_if.dividend_i[XLEN-1] ^ div_if.divisor_i[XLEN-1]) & ~dvs_zero;
          neg_rem_d  = op_signed & div_if.dividend_i[XLEN-1];
          state_d    = DIV_CALC;
`ifdef EX_DIV_FAST_EN
          if (dvs_zero || (abs_b > abs_a)) begin
            quot_d  = dvs_zero ? {XLEN{1'b1}} : {XLEN{1'b0}};
            rem_d   = abs_a;
            state_d = DIV_DONE;
          end
`else
`endif
        end
      end
      DIV_CALC: begin
        if (div_if.flush_i) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], ~diff[XLEN]};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  assign quot_fix = neg_quot_q ? negate(quot_q) : quot_q;
  assign rem_fix  = neg_rem_q  ? negate(rem_q)  : rem_q;

  assign div_if.ready_o     = (state_q == DIV_DONE) & ~div_if.flush_i;
  assign div_if.result_o    = div_if.ready_o ? (rem_sel_q ? rem_fix : quot_fix) : '0;
  assign div_if.reg_waddr_o = waddr_q;
  assign div_if.busy_o      = (state_q != DIV_IDLE);
  assign div_if.stall_o     = ((state_q == DIV_IDLE) & div_if.start_i & ~div_if.flush_i)
                            | (state_q == DIV_CALC);

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed + random bench for ex_div_unit with a result scoreboard.
// Build with +define+EX_DIV_FAST_EN to exercise the early-out path.
module tb_ex_div_unit;
  import ex_div_unit_pkg::*;

`ifdef EX_DIV_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int FULL_LAT   = 33;
  localparam int FULL_STALL = 33;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  ex_div_unit_if dif();

  ex_div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb_;
    logic ovf;
    sa  = a;
    sb_ = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      INST_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb_));
      INST_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      INST_REM:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb_));
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drive one op, keep start_i high with junk operands while busy, wait for ready_o.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic [31:0] exp, input string tag,
                       input int exp_lat, input int exp_stall);
    int   lat, stalls;
    bit   seen;
    exp_t e;
    sb.push_back('{res: exp, wa: wa});
    dif.start_i = 1'b1; dif.op_i = op; dif.dividend_i = a; dif.divisor_i = b; dif.reg_waddr_i = wa;
    #1;
    stalls = dif.stall_o ? 1 : 0;
    @(posedge clk);
    @(negedge clk);
    dif.dividend_i = $urandom; dif.divisor_i = $urandom; dif.reg_waddr_i = 5'($urandom);
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dif.ready_o) begin
        seen = 1'b1;
        break;
      end
      if (dif.stall_o) stalls++;
      @(negedge clk);
      lat++;
    end
    dif.start_i = 1'b0;
    check({tag, " ready_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    if (seen) begin
      check({tag, " result"}, dif.result_o, e.res);
      check({tag, " waddr"}, 32'(dif.reg_waddr_o), 32'(e.wa));
      check({tag, " stall_in_done"}, 32'(dif.stall_o), 32'd0);
      if (exp_lat > 0) begin
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
      end
    end
    @(negedge clk);
    check({tag, " ready_pulse"}, {30'd0, dif.ready_o, dif.busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    dif.start_i = 1'b0; dif.op_i = INST_DIVU; dif.dividend_i = '0; dif.divisor_i = '0;
    dif.reg_waddr_i = '0; dif.flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy",   32'(dif.busy_o),      32'd0);
    check("reset ready",  32'(dif.ready_o),     32'd0);
    check("reset result", dif.result_o,         32'd0);
    check("reset waddr",  32'(dif.reg_waddr_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_op(INST_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, "divu_100_7", FULL_LAT, FULL_STALL);
    do_op(INST_REMU, 32'd100, 32'd7, 5'd4, 32'd2,  "remu_100_7", FULL_LAT, FULL_STALL);
    do_op(INST_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, "div_m7_2", FULL_LAT, FULL_STALL);
    do_op(INST_REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, "rem_m7_2", FULL_LAT, FULL_STALL);
    do_op(INST_DIV,  32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, "div_7_m2", FULL_LAT, FULL_STALL);
    do_op(INST_REM,  32'd7, 32'hFFFF_FFFE, 5'd8, 32'd1,         "rem_7_m2", FULL_LAT, FULL_STALL);
    do_op(INST_DIV,  32'h1234_5678, 32'd0, 5'd9,  32'hFFFF_FFFF, "div_by0",  FAST ? 1 : FULL_LAT, FAST ? 1 : FULL_STALL);
    do_op(INST_REM,  32'h1234_5678, 32'd0, 5'd10, 32'h1234_5678, "rem_by0",  FAST ? 1 : FULL_LAT, FAST ? 1 : FULL_STALL);
    do_op(INST_DIVU, 32'd0, 32'd0, 5'd11, 32'hFFFF_FFFF, "divu_0_0", FAST ? 1 : FULL_LAT, FAST ? 1 : FULL_STALL);
    do_op(INST_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, "div_ovf", FULL_LAT, FULL_STALL);
    do_op(INST_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0,         "rem_ovf", FULL_LAT, FULL_STALL);
    // Early-out on the fast build: ready in the cycle right after the accept edge.
    do_op(INST_DIVU, 32'd3, 32'd10, 5'd14, 32'd0, "divu_3_10", FAST ? 1 : FULL_LAT, FAST ? 1 : FULL_STALL);
    do_op(INST_REMU, 32'd3, 32'd10, 5'd15, 32'd3, "remu_3_10", FAST ? 1 : FULL_LAT, FAST ? 1 : FULL_STALL);

    // Flush at CALC cycle 10.
    dif.start_i = 1'b1; dif.op_i = INST_DIVU; dif.dividend_i = 32'd1000; dif.divisor_i = 32'd3;
    dif.reg_waddr_i = 5'd20;
    @(posedge clk);
    @(negedge clk);
    dif.start_i = 1'b0;
    repeat (9) @(negedge clk);
    dif.flush_i = 1'b1;
    #1;
    check("flush ready", 32'(dif.ready_o), 32'd0);
    @(negedge clk);
    dif.flush_i = 1'b0;
    check("flush busy",  32'(dif.busy_o),  32'd0);
    check("flush ready_next", 32'(dif.ready_o), 32'd0);
    check("flush stall", 32'(dif.stall_o), 32'd0);
    do_op(INST_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, "divu_9_3", FULL_LAT, FULL_STALL);

    // start and flush together in IDLE: not accepted.
    dif.start_i = 1'b1; dif.flush_i = 1'b1; dif.op_i = INST_DIVU;
    dif.dividend_i = 32'd50; dif.divisor_i = 32'd5;
    #1;
    check("startflush stall", 32'(dif.stall_o), 32'd0);
    @(negedge clk);
    dif.start_i = 1'b0; dif.flush_i = 1'b0;
    check("startflush busy", 32'(dif.busy_o), 32'd0);

    // Reset mid-CALC.
    dif.start_i = 1'b1; dif.op_i = INST_DIVU; dif.dividend_i = 32'd77; dif.divisor_i = 32'd5;
    dif.reg_waddr_i = 5'd29;
    @(posedge clk);
    @(negedge clk);
    dif.start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst busy",  32'(dif.busy_o),      32'd0);
    check("midrst stall", 32'(dif.stall_o),     32'd0);
    check("midrst ready", 32'(dif.ready_o),     32'd0);
    check("midrst waddr", 32'(dif.reg_waddr_o), 32'd0);
    check("midrst result", dif.result_o,        32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      rop = 3'(4 + $urandom_range(0, 3));
      ra  = $urandom;
      rb  = (k % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (k == 5) rb = 32'hFFFF_FFFF;
      do_op(rop, ra, rb, 5'(k + 1), ref_div(rop, ra, rb), $sformatf("rand%0d", k), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
